// File: rtl/pico_out_regs_pkg.sv
// Shared definitions for the PicoBlaze output-port register block and the
// matching input-side read multiplexer: port addresses, register indices,
// burst FSM encoding and the RTC burst word payload.
package pico_out_regs_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PORT_W   = 8;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_REGS = 9;

  // Output port addresses, one per time/date register
  localparam logic [PORT_W-1:0] PORT_SEG   = 8'h01;
  localparam logic [PORT_W-1:0] PORT_MIN   = 8'h02;
  localparam logic [PORT_W-1:0] PORT_HORA  = 8'h03;
  localparam logic [PORT_W-1:0] PORT_CSEG  = 8'h04;
  localparam logic [PORT_W-1:0] PORT_CMIN  = 8'h05;
  localparam logic [PORT_W-1:0] PORT_CHORA = 8'h06;
  localparam logic [PORT_W-1:0] PORT_DIA   = 8'h07;
  localparam logic [PORT_W-1:0] PORT_MES   = 8'h08;
  localparam logic [PORT_W-1:0] PORT_ANO   = 8'h09;

  localparam logic [PORT_W-1:0] CMD_PORT_DEFAULT = 8'h0B;

  // Register indices as seen by the RTC writer (1-based, 0 means none)
  localparam logic [IDX_W-1:0] IDX_NONE  = 4'd0;
  localparam logic [IDX_W-1:0] IDX_SEG   = 4'd1;
  localparam logic [IDX_W-1:0] IDX_MIN   = 4'd2;
  localparam logic [IDX_W-1:0] IDX_HORA  = 4'd3;
  localparam logic [IDX_W-1:0] IDX_CSEG  = 4'd4;
  localparam logic [IDX_W-1:0] IDX_CMIN  = 4'd5;
  localparam logic [IDX_W-1:0] IDX_CHORA = 4'd6;
  localparam logic [IDX_W-1:0] IDX_DIA   = 4'd7;
  localparam logic [IDX_W-1:0] IDX_MES   = 4'd8;
  localparam logic [IDX_W-1:0] IDX_ANO   = 4'd9;

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_SEG;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_ANO;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One word of the commit burst toward the RTC writer
  typedef struct packed {
    logic [IDX_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } rtc_word_t;

  // Map a port address to its register index; IDX_NONE for non-data ports
  function automatic logic [IDX_W-1:0] port_to_idx(input logic [PORT_W-1:0] port);
    logic [IDX_W-1:0] idx;
    idx = IDX_NONE;
    case (port)
      PORT_SEG:   idx = IDX_SEG;
      PORT_MIN:   idx = IDX_MIN;
      PORT_HORA:  idx = IDX_HORA;
      PORT_CSEG:  idx = IDX_CSEG;
      PORT_CMIN:  idx = IDX_CMIN;
      PORT_CHORA: idx = IDX_CHORA;
      PORT_DIA:   idx = IDX_DIA;
      PORT_MES:   idx = IDX_MES;
      PORT_ANO:   idx = IDX_ANO;
      default:    idx = IDX_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pico_bcd_check.sv
// Combinational BCD validity check of a data byte (both nibbles 0..9).
// Only present when PICO_OUT_BCD_CHECK_EN is defined.
// Ports:
//   data      in  8  byte to check
//   bcd_ok_c  out 1  high when both nibbles are decimal digits
`ifdef PICO_OUT_BCD_CHECK_EN
module pico_bcd_check
  import pico_out_regs_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              bcd_ok_c
);

  assign bcd_ok_c = (data[7:4] <= 4'd9) && (data[3:0] <= 4'd9);

endmodule
`endif

// File: rtl/pico_out_regs.sv
// PicoBlaze output-port register bank with an RTC commit burst.
// Writes to ports 0x01..0x09 load the live time/date registers. A write to
// CMD_PORT while idle snapshots all nine registers and streams them to the
// RTC writer as nine valid/ready words (index 1..9), followed by a
// one-cycle done pulse. A command while busy is dropped and flags err.
// Optional macro PICO_OUT_BCD_CHECK_EN: reject non-BCD data writes and
// flag err.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   write_strobe, port_id, out_port  PicoBlaze output bus
//   seg..ano                       live register values (ports 0x01..0x09)
//   rtc_valid/addr/data, rtc_ready burst handshake toward the RTC writer
//   busy, done, err                burst status, done pulse, sticky error
module pico_out_regs
  import pico_out_regs_pkg::*;
#(
  parameter logic [PORT_W-1:0] CMD_PORT = CMD_PORT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_strobe,
  input  logic [PORT_W-1:0] port_id,
  input  logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] seg,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] hora,
  output logic [DATA_W-1:0] cseg,
  output logic [DATA_W-1:0] cmin,
  output logic [DATA_W-1:0] chora,
  output logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] mes,
  output logic [DATA_W-1:0] ano,
  output logic              rtc_valid,
  output logic [IDX_W-1:0]  rtc_addr,
  output logic [DATA_W-1:0] rtc_data,
  input  logic              rtc_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [DATA_W-1:0] live_q [1:NUM_REGS];
  logic [DATA_W-1:0] snap_q [1:NUM_REGS];

  state_t    state_q, state_d;
  rtc_word_t word_q,  word_d;
  logic      valid_q, valid_d;
  logic      busy_q,  busy_d;
  logic      done_q,  done_d;
  logic      err_q,   err_d;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             data_wr;
  logic             cmd_wr;
  logic             take_snap;
  logic             hs;
  logic             bcd_ok_c;

  // Write decode: port_id selects exactly one of data write or command
  assign wr_idx    = port_to_idx(port_id);
  assign data_wr   = write_strobe && (wr_idx != IDX_NONE);
  assign cmd_wr    = write_strobe && (port_id == CMD_PORT);
  assign take_snap = cmd_wr && (state_q == ST_IDLE);
  assign hs        = valid_q && rtc_ready;
  assign nxt_idx   = word_q.addr + IDX_W'(1);

`ifdef PICO_OUT_BCD_CHECK_EN
  pico_bcd_check u_bcd_check (
    .data     (out_port),
    .bcd_ok_c (bcd_ok_c)
  );
`else
  assign bcd_ok_c = 1'b1;
`endif

  // Live registers: updated in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= NUM_REGS; i++) begin
        live_q[i] <= '0;
      end
    end else if (data_wr && bcd_ok_c) begin
      live_q[wr_idx] <= out_port;
    end
  end

  // Snapshot bank: frozen copy sent by the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= NUM_REGS; i++) begin
        snap_q[i] <= '0;
      end
    end else if (take_snap) begin
      snap_q <= live_q;
    end
  end

  // FSM state and registered burst outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_wr) begin
          // Live value of index 1 equals the snapshot taken on this edge
          state_d = ST_SEND;
          word_d  = '{addr: IDX_FIRST, data: live_q[IDX_FIRST]};
          valid_d = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_SEND: begin
        if (cmd_wr) begin
          err_d = 1'b1;
        end
        if (hs) begin
          if (word_q.addr == IDX_LAST) begin
            state_d = ST_DONE;
            word_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            word_d = '{addr: nxt_idx, data: snap_q[nxt_idx]};
          end
        end
      end
      ST_DONE: begin
        if (cmd_wr) begin
          err_d = 1'b1;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Rejected non-BCD data write (never true without the check)
    if (data_wr && !bcd_ok_c) begin
      err_d = 1'b1;
    end
  end

  assign seg   = live_q[IDX_SEG];
  assign min   = live_q[IDX_MIN];
  assign hora  = live_q[IDX_HORA];
  assign cseg  = live_q[IDX_CSEG];
  assign cmin  = live_q[IDX_CMIN];
  assign chora = live_q[IDX_CHORA];
  assign dia   = live_q[IDX_DIA];
  assign mes   = live_q[IDX_MES];
  assign ano   = live_q[IDX_ANO];

  assign rtc_valid = valid_q;
  assign rtc_addr  = word_q.addr;
  assign rtc_data  = word_q.data;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/pico_out_regs.md
PICO_OUT_REGS -- requirements
Module: pico_out_regs

Interface
REQ-001 The block SHALL have parameter CMD_PORT, default 8'h0B, giving the port_id that starts a commit burst.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 write_strobe  input  1  PicoBlaze output-write qualifier, one cycle wide.
REQ-005 port_id  input  8  PicoBlaze port address.
REQ-006 out_port  input  8  PicoBlaze write data.
REQ-007 seg, min, hora, cseg, cmin, chora, dia, mes, ano  output  8 each  registered values for ports 8'h01..8'h09, in that order.
REQ-008 rtc_valid  output  1  burst word valid toward the RTC writer.
REQ-009 rtc_addr  output  4  register index 1..9 of the current burst word.
REQ-010 rtc_data  output  8  snapshot data of the current burst word.
REQ-011 rtc_ready  input  1  RTC writer accepts the word when high with rtc_valid.
REQ-012 busy  output  1  high while the burst is in progress (states SEND and DONE).
REQ-013 done  output  1  one-cycle pulse after the last word is accepted.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 A write_strobe=1 with port_id in 8'h01..8'h09 SHALL load out_port into the matching register at the next edge, whether idle or busy.
REQ-016 Writes to any other port except CMD_PORT SHALL be ignored.
REQ-017 FSM states: IDLE, SEND, DONE.
REQ-018 In IDLE, a write to CMD_PORT SHALL copy all nine registers into a snapshot bank, set index to 1, clear err, and move to SEND on the same edge.
REQ-019 A write to CMD_PORT on the same edge as a data-port write SHALL be impossible; the single port_id decides which one applies.
REQ-020 In SEND: rtc_valid=1, rtc_addr=index, rtc_data=snapshot[index]; addr and data SHALL stay stable until rtc_valid and rtc_ready are both high.
REQ-021 On handshake with index<9, index SHALL increment. With index=9, the FSM SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1 and rtc_valid=0, then return to IDLE.
REQ-023 A CMD_PORT write while busy SHALL be dropped and SHALL set err.
REQ-024 Data-port writes during a burst SHALL update the live registers only; the burst SHALL send snapshot values.
REQ-025 Minimum burst length: 9 cycles with rtc_ready held high, plus 1 DONE cycle.

Reset
REQ-026 Asserting rst_n low SHALL, asynchronously:
- clear all nine registers and the snapshot bank to 8'h00;
- force the FSM to IDLE;
- set rtc_valid, busy, done and err to 0, rtc_addr to 0 and rtc_data to 8'h00.
REQ-027 Reset during a burst SHALL abort it with no done pulse; the first cycle after release SHALL be IDLE.

Configuration
REQ-028 With PICO_OUT_BCD_CHECK_EN defined, a data-port write with either nibble >9 SHALL be rejected (register unchanged) and SHALL set err.
REQ-029 Without PICO_OUT_BCD_CHECK_EN, all data-port writes SHALL be accepted and BCD validity SHALL never set err.

Structure
REQ-030 A shared package SHALL hold:
- port-address constants 8'h01..8'h09 and the default CMD_PORT;
- the FSM state encoding;
- the register-index constants.
These are shared with the input-side read multiplexer.
REQ-031 One sub-module, pico_bcd_check (combinational nibble validity), SHALL be instantiated only when PICO_OUT_BCD_CHECK_EN is defined.

Verification
REQ-032 Reset then write 8'h45 to port 8'h02 -> min=8'h45 one edge later; all other registers remain 8'h00.
REQ-033 Load 8'h01..8'h09 into ports 1..9, write CMD_PORT, hold rtc_ready=1 -> nine words (addr 1..9, data 8'h01..8'h09) on consecutive cycles, then one done pulse, then busy=0.
REQ-034 Burst with rtc_ready low for 3 cycles at addr 4 -> addr 4 and its data held stable all 3 cycles; no word skipped or repeated.
REQ-035 During a burst, write 8'h59 to port 8'h01 and write CMD_PORT -> seg=8'h59, burst still sends the snapshot seg value, err=1, no second burst.
REQ-036 With PICO_OUT_BCD_CHECK_EN, write 8'h7A to port 8'h03 -> hora unchanged, err=1; without the macro -> hora=8'h7A, err=0.
REQ-037 Drop rst_n at addr 5 of a burst -> outputs take reset values immediately, no done pulse, IDLE after release.
